// File: rtl/accum_pkg.sv
// Shared types and sizing helpers for the accumulator drain block.
// Holds the default word width, FSM state type and length-width helper.
package accum_pkg;

   localparam int A_BITS_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int len_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/accum_skid_buffer.sv
// Two-entry in-order buffer carrying a data word and its last flag.
// Entry 0 is always the oldest word and drives the outputs directly.
module accum_skid_buffer #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         push_last,
   input  logic         pop,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic [1:0]   occupancy
);

   logic [W-1:0] d0_q;
   logic [W-1:0] d1_q;
   logic         l0_q;
   logic         l1_q;
   logic [1:0]   occ_q;
   logic         do_push;
   logic         do_pop;

   assign do_push   = push & (occ_q != 2'd2);
   assign do_pop    = pop & (occ_q != 2'd0);
   assign out_data  = d0_q;
   assign out_last  = l0_q;
   assign occupancy = occ_q;

   // Shift/fill the two slots so entry 0 always holds the oldest word.
   always_ff @(posedge clock) begin
      if (reset) begin
         d0_q  <= '0;
         d1_q  <= '0;
         l0_q  <= 1'b0;
         l1_q  <= 1'b0;
         occ_q <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (occ_q == 2'd0) begin
                  d0_q <= push_data;
                  l0_q <= push_last;
               end else begin
                  d1_q <= push_data;
                  l1_q <= push_last;
               end
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               d0_q  <= d1_q;
               l0_q  <= l1_q;
               l1_q  <= 1'b0;
               occ_q <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  d0_q <= push_data;
                  l0_q <= push_last;
               end else begin
                  d0_q <= d1_q;
                  l0_q <= l1_q;
                  d1_q <= push_data;
                  l1_q <= push_last;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/accum_drain.sv
// Drains len accumulator words from an upstream queue into a valid/ready stream.
// Optional ACCUM_DRAIN_RELU_EN zeroes negative words as they are captured.
module accum_drain
   import accum_pkg::*;
#(
   parameter  int A_BITS      = A_BITS_DEF,
   parameter  int FIFO_LENGTH = 8,
   localparam int LEN_BITS    = len_bits(FIFO_LENGTH)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [LEN_BITS-1:0] len,
   output logic                stall,
   input  logic [A_BITS-1:0]   a_in,
   output logic [A_BITS-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy,
   output logic                done
);

   state_t              state_q;
   state_t              state_d;
   logic [LEN_BITS-1:0] rem_q;
   logic [LEN_BITS-1:0] rem_d;
   logic [1:0]          occ;
   logic                cap;
   logic                cap_last;
   logic                pop;
   logic                buf_last;
   logic [A_BITS-1:0]   cap_data;

   // Stall comes only from registers so the queue sees no combinational path.
   assign stall = (state_q != DRAIN)
                | (occ == 2'd2)
                | (rem_q == '0);

   assign cap       = ~stall;
   assign cap_last  = cap & (rem_q == LEN_BITS'(1));
   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid & out_ready;
   assign out_last  = buf_last & out_valid;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

`ifdef ACCUM_DRAIN_RELU_EN
   assign cap_data = a_in[A_BITS-1] ? '0 : a_in;
`else
   assign cap_data = a_in;
`endif

   accum_skid_buffer #(
      .W (A_BITS)
   ) u_buf (
      .clock     (clock),
      .reset     (reset),
      .push      (cap),
      .push_data (cap_data),
      .push_last (cap_last),
      .pop       (pop),
      .out_data  (out_data),
      .out_last  (buf_last),
      .occupancy (occ)
   );

   // Next-state and remaining-count logic for the drain sequence.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = DRAIN;
                  rem_d   = len;
               end
            end
         end
         DRAIN: begin
            if (cap) begin
               rem_d = rem_q - LEN_BITS'(1);
            end
            if (pop & out_last) begin
               state_d = DONE;
            end else if (cap_last) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (pop & out_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and remaining-count registers; reset abandons any drain.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

endmodule

// File: tb/tb_accum_drain.sv
// Self-checking bench for accum_drain.
// Table-driven drains plus hand sequences for backpressure and reset.
module tb_accum_drain;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  len = '0;
   logic        stall;
   logic [31:0] a_in;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic        busy;
   logic        done;

   always #5 clock = ~clock;

   accum_drain dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .len       (len),
      .stall     (stall),
      .a_in      (a_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   logic [31:0] q_mem [0:31];
   logic [4:0]  q_idx;
   logic        q_rst = 1'b1;

   // Upstream queue: advances only when stall is low.
   always @(posedge clock) begin
      if (q_rst) q_idx <= '0;
      else if (!stall) q_idx <= q_idx + 5'd1;
   end
   assign a_in = q_mem[q_idx];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic qreset();
      q_rst = 1'b1;
      tick();
      q_rst = 1'b0;
   endtask

   typedef struct {
      logic        st;
      logic [3:0]  ln;
      logic        rdy;
      logic        e_stall;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_last;
      logic        e_busy;
      logic        e_done;
   } vec_t;

   vec_t tbl [15];

   logic [31:0] pops [$];
   logic        plast [$];
   logic        st_h [64];
   logic [31:0] d_h [64];

   task automatic drain(input int n, input int lo0, input int lo1);
      bit fin;
      fin = 0;
      pops.delete();
      plast.delete();
      start = 1'b1;
      len = 4'(n);
      for (int r = 0; r < 60 && !fin; r++) begin
         out_ready = !(r >= lo0 && r <= lo1);
         @(negedge clock);
         st_h[r] = stall;
         d_h[r] = out_data;
         if (out_valid && out_ready) begin
            pops.push_back(out_data);
            plast.push_back(out_last);
         end
         if (done) fin = 1;
         tick();
         start = 1'b0;
      end
      if (!fin) begin
         n_chk++;
         n_err++;
         $display("FAIL drain_timeout: got no done, expected done within 60 cycles");
      end
      @(negedge clock);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) q_mem[i] = 32'(i);

      tbl[0]  = '{1'b1, 4'd8, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0};
      for (int r = 2; r <= 8; r++)
         tbl[r] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 32'(r - 2),
                    1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 32'd7, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};

      // Reset held for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clock);
         chk($sformatf("rst_stall_%0d", i), {31'd0, stall}, 32'd1);
         chk($sformatf("rst_valid_%0d", i), {31'd0, out_valid}, 32'd0);
         chk($sformatf("rst_busy_%0d", i), {31'd0, busy}, 32'd0);
      end
      chk("rst_data", out_data, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      tick();
      reset = 1'b0;
      q_rst = 1'b0;

      // Full-rate len=8 drain followed by a len=0 request.
      for (int r = 0; r < 15; r++) begin
         start = tbl[r].st;
         len = tbl[r].ln;
         out_ready = tbl[r].rdy;
         @(negedge clock);
         chk($sformatf("v%0d_stall", r), {31'd0, stall},
             {31'd0, tbl[r].e_stall});
         chk($sformatf("v%0d_valid", r), {31'd0, out_valid},
             {31'd0, tbl[r].e_valid});
         chk($sformatf("v%0d_last", r), {31'd0, out_last},
             {31'd0, tbl[r].e_last});
         chk($sformatf("v%0d_busy", r), {31'd0, busy},
             {31'd0, tbl[r].e_busy});
         chk($sformatf("v%0d_done", r), {31'd0, done},
             {31'd0, tbl[r].e_done});
         if (tbl[r].e_valid)
            chk($sformatf("v%0d_data", r), out_data, tbl[r].e_data);
         tick();
      end
      start = 1'b0;

      // Backpressure: out_ready low for rows 3..6.
      qreset();
      drain(8, 3, 6);
      chk("bp_stall_r3", {31'd0, st_h[3]}, 32'd0);
      for (int r = 4; r <= 6; r++) begin
         chk($sformatf("bp_stall_r%0d", r), {31'd0, st_h[r]}, 32'd1);
         chk($sformatf("bp_hold_r%0d", r), d_h[r], 32'd1);
      end
      chk("bp_stall_r8", {31'd0, st_h[8]}, 32'd0);
      chk("bp_count", 32'(pops.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < pops.size()) begin
            chk($sformatf("bp_word%0d", i), pops[i], 32'(i));
            chk($sformatf("bp_last%0d", i), {31'd0, plast[i]},
                {31'd0, i == 7});
         end
      end

      // Reset mid-drain after three captures.
      qreset();
      start = 1'b1;
      len = 4'd8;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      @(negedge clock);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("mr_stall", {31'd0, stall}, 32'd1);
      chk("mr_valid", {31'd0, out_valid}, 32'd0);
      chk("mr_last", {31'd0, out_last}, 32'd0);
      chk("mr_busy", {31'd0, busy}, 32'd0);
      chk("mr_done", {31'd0, done}, 32'd0);
      chk("mr_data", out_data, 32'd0);
      tick();
      qreset();
      drain(4, -1, -1);
      chk("mr4_count", 32'(pops.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < pops.size()) begin
            chk($sformatf("mr4_word%0d", i), pops[i], 32'(i));
            chk($sformatf("mr4_last%0d", i), {31'd0, plast[i]},
                {31'd0, i == 3});
         end
      end

      // Sign handling at capture.
      q_mem[0] = 32'hFFFF_FFFB;
      q_mem[1] = 32'd7;
      qreset();
      drain(2, -1, -1);
      chk("sg_count", 32'(pops.size()), 32'd2);
      if (pops.size() == 2) begin
`ifdef ACCUM_DRAIN_RELU_EN
         chk("sg_word0", pops[0], 32'd0);
`else
         chk("sg_word0", pops[0], 32'hFFFF_FFFB);
`endif
         chk("sg_word1", pops[1], 32'd7);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
